mul_pipe_hs: RTL and testbench

//  Parametrised handshake successor of the fixed mul stage-2 pipe. Computes sign, biased exponent sum and full mantissa

---
 rtl/mul_pipe_pkg.sv | 16 +
 rtl/mul_pipe_slice.sv | 40 ++++
 rtl/mul_pipe_hs.sv | 135 +++++++++++++
 tb/tb_mul_pipe_hs.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// Shared helpers for the mul_pipe_hs mantissa/exponent multiplier pipe.
// The stage payload struct lives in the top because its field widths follow the top's parameters.
package mul_pipe_pkg;

  localparam int STAGES_MAX = 4;

  function automatic int bias(input int expo_w);
    return (1 << (expo_w - 1)) - 1;
  endfunction

  // Packed width of one stage payload {sign, expo, mant, side}.
  function automatic int payload_w(input int expo_w, input int mant_w, input int side_w);
    return 1 + (expo_w + 2) + (2 * mant_w + 2) + side_w;
  endfunction

endpackage

// File: rtl/mul_pipe_slice.sv
// One valid/data register slice with bubble-collapsing ready logic.
// ready is combinational from down_ready, so a full chain passes backpressure in one cycle.
module mul_pipe_slice
  import mul_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  assign ready = !valid || down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
    end
  end

  // Data is only captured on a real transfer so a stalled beat stays stable; flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (!flush && ready && up_valid) begin
      data <= up_data;
    end
  end

endmodule

// File: rtl/mul_pipe_hs.sv
// Handshake FP multiply core: sign, biased exponent sum and full mantissa product over STAGES slices.
// Optional performance counters are enabled by defining MUL_PIPE_PERF_EN.
module mul_pipe_hs
  import mul_pipe_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int STAGES = 2,
  parameter int SIDE_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     a_sign,
  input  logic                     b_sign,
  input  logic [EXPO_W-1:0]        a_expo,
  input  logic [EXPO_W-1:0]        b_expo,
  input  logic [MANT_W-1:0]        a_mant,
  input  logic [MANT_W-1:0]        b_mant,
  input  logic                     a_sub,
  input  logic                     b_sub,
  input  logic [SIDE_W-1:0]        side_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sign_1,
  output logic signed [EXPO_W+1:0] expo_1,
  output logic [2*MANT_W+1:0]      mant_1,
  output logic [SIDE_W-1:0]        side_out,
  output logic                     busy
`ifdef MUL_PIPE_PERF_EN
  ,
  output logic [31:0]              beat_cnt,
  output logic [31:0]              stall_cnt
`endif
);

  typedef struct packed {
    logic                     sign;
    logic signed [EXPO_W+1:0] expo;
    logic [2*MANT_W+1:0]      mant;
    logic [SIDE_W-1:0]        side;
  } payload_t;

  localparam int PW = $bits(payload_t);
  localparam logic signed [EXPO_W+1:0] BIAS_S = (EXPO_W + 2)'(bias(EXPO_W));

  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("mul_pipe_hs: STAGES must be in 1..%0d", STAGES_MAX);
  end

  if (PW != payload_w(EXPO_W, MANT_W, SIDE_W)) begin : g_bad_width
    $error("mul_pipe_hs: payload width mismatch");
  end

  payload_t                 in_pl;
  payload_t                 out_pl;
  logic signed [EXPO_W+1:0] ea;
  logic signed [EXPO_W+1:0] eb;
  logic [MANT_W:0]          ma;
  logic [MANT_W:0]          mb;

  // Subnormals read their exponent as 1 and drop the hidden bit; the extra two exponent bits avoid wrap.
  always_comb begin
    ea = a_sub ? (EXPO_W + 2)'(1) : (EXPO_W + 2)'(a_expo);
    eb = b_sub ? (EXPO_W + 2)'(1) : (EXPO_W + 2)'(b_expo);
    ma = {~a_sub, a_mant};
    mb = {~b_sub, b_mant};
    in_pl.sign = a_sign ^ b_sign;
    in_pl.expo = ea + eb - BIAS_S;
    in_pl.mant = (2 * MANT_W + 2)'(ma) * (2 * MANT_W + 2)'(mb);
    in_pl.side = side_in;
  end

  logic          stage_valid [STAGES];
  logic [PW-1:0] stage_data  [STAGES];
  logic          stage_ready [STAGES+1];

  assign stage_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          up_v;
    logic [PW-1:0] up_d;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_pl;
    end else begin : g_body
      assign up_v = stage_valid[k-1];
      assign up_d = stage_data[k-1];
    end

    mul_pipe_slice #(.W(PW)) u_slice (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (up_v),
      .up_data    (up_d),
      .down_ready (stage_ready[k+1]),
      .ready      (stage_ready[k]),
      .valid      (stage_valid[k]),
      .data       (stage_data[k])
    );
  end

  assign in_ready  = !flush && stage_ready[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_pl    = payload_t'(stage_data[STAGES-1]);
  assign sign_1    = out_pl.sign;
  assign expo_1    = out_pl.expo;
  assign mant_1    = out_pl.mant;
  assign side_out  = out_pl.side;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      busy = busy | stage_valid[k];
    end
  end

`ifdef MUL_PIPE_PERF_EN
  // Counters survive flush and simply wrap; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready) beat_cnt <= beat_cnt + 32'd1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Scoreboard bench for mul_pipe_hs: a driver pushes model results on accept, a monitor pops on delivery.
// Builds with or without MUL_PIPE_PERF_EN.
module tb_mul_pipe_hs;

  localparam int EXPO_W = 8;
  localparam int MANT_W = 23;
  localparam int STAGES = 2;
  localparam int SIDE_W = 16;
  localparam int BIAS   = (1 << (EXPO_W - 1)) - 1;

  typedef struct {
    bit              a_sign, b_sign, a_sub, b_sub;
    bit [EXPO_W-1:0] a_expo, b_expo;
    bit [MANT_W-1:0] a_mant, b_mant;
    bit [SIDE_W-1:0] side;
  } beat_t;

  typedef struct {
    bit              sign;
    int              expo;
    longint unsigned mant;
    bit [SIDE_W-1:0] side;
    int              acc;
  } exp_t;

  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic a_sign = 0, b_sign = 0, a_sub = 0, b_sub = 0;
  logic [EXPO_W-1:0] a_expo = '0, b_expo = '0;
  logic [MANT_W-1:0] a_mant = '0, b_mant = '0;
  logic [SIDE_W-1:0] side_in = '0;
  logic in_ready, out_valid, sign_1, busy;
  logic signed [EXPO_W+1:0] expo_1;
  logic [2*MANT_W+1:0] mant_1;
  logic [SIDE_W-1:0] side_out;
`ifdef MUL_PIPE_PERF_EN
  logic [31:0] beat_cnt, stall_cnt;
`endif

  exp_t sb[$];
  int   cyc = 0, n_checks = 0, n_fail = 0, rdy_mode = 0;
  int   m_beats = 0, m_stalls = 0;
  bit   strict_lat = 0, prev_stall = 0;
  logic prev_sign;
  logic signed [EXPO_W+1:0] prev_expo;
  logic [2*MANT_W+1:0] prev_mant;
  logic [SIDE_W-1:0] prev_side;
  exp_t head;

  mul_pipe_hs #(.EXPO_W(EXPO_W), .MANT_W(MANT_W), .STAGES(STAGES), .SIDE_W(SIDE_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_expo(a_expo), .b_expo(b_expo),
    .a_mant(a_mant), .b_mant(b_mant), .a_sub(a_sub), .b_sub(b_sub), .side_in(side_in),
    .out_valid(out_valid), .out_ready(out_ready), .sign_1(sign_1), .expo_1(expo_1),
    .mant_1(mant_1), .side_out(side_out), .busy(busy)
`ifdef MUL_PIPE_PERF_EN
    , .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream acceptance pattern: 0 = always ready, 2 = never ready, otherwise random.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t refModel(input beat_t b);
    exp_t r;
    int ea, eb;
    longint unsigned ma, mb;
    ea = b.a_sub ? 1 : int'(b.a_expo);
    eb = b.b_sub ? 1 : int'(b.b_expo);
    ma = (b.a_sub ? 64'd0 : (64'd1 << MANT_W)) + 64'(b.a_mant);
    mb = (b.b_sub ? 64'd0 : (64'd1 << MANT_W)) + 64'(b.b_mant);
    r.sign = b.a_sign ^ b.b_sign;
    r.expo = ea + eb - BIAS;
    r.mant = ma * mb;
    r.side = b.side;
    r.acc  = 0;
    return r;
  endfunction

  function automatic beat_t randBeat();
    beat_t b;
    b.a_sign = 1'($urandom_range(0, 1));
    b.b_sign = 1'($urandom_range(0, 1));
    b.a_sub  = ($urandom_range(0, 3) == 0);
    b.b_sub  = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 3))
      0: b.a_expo = '0;
      1: b.a_expo = '1;
      default: b.a_expo = EXPO_W'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: b.b_expo = '0;
      1: b.b_expo = '1;
      default: b.b_expo = EXPO_W'($urandom);
    endcase
    b.a_mant = ($urandom_range(0, 5) == 0) ? '1 : MANT_W'($urandom);
    b.b_mant = ($urandom_range(0, 5) == 0) ? '0 : MANT_W'($urandom);
    b.side   = SIDE_W'($urandom);
    return b;
  endfunction

  task automatic driveBeat(input beat_t b);
    a_sign = b.a_sign; b_sign = b.b_sign; a_sub = b.a_sub; b_sub = b.b_sub;
    a_expo = b.a_expo; b_expo = b.b_expo; a_mant = b.a_mant; b_mant = b.b_mant;
    side_in = b.side;
  endtask

  // Starts and ends at posedge+1; pushes the expected result on the cycle the beat is accepted.
  task automatic applyStimulus(input beat_t b, input exp_t e);
    int waited = 0;
    driveBeat(b);
    in_valid = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (in_ready) begin
        e.acc = cyc + 1;
        sb.push_back(e);
        break;
      end
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", 1'b0, waited, 200);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic applyRandom(input int n, input int idle_max);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = randBeat();
      applyStimulus(b, refModel(b));
      repeat ($urandom_range(0, idle_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic flushPipe(input bit with_beat);
    driveBeat(randBeat());
    flush = 1'b1;
    in_valid = with_beat;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain", sb.size() == 0, sb.size(), 0);
  endtask

  task automatic checkOutput(input exp_t e, input int dcyc);
    chk("sign_1", sign_1 == e.sign, sign_1, e.sign);
    chk("expo_1", int'(expo_1) == e.expo, int'(expo_1), e.expo);
    chk("mant_1", 64'(mant_1) == e.mant, 64'(mant_1), e.mant);
    chk("side_out", side_out == e.side, side_out, e.side);
    if (strict_lat) chk("latency", dcyc - e.acc == STAGES, dcyc - e.acc, STAGES);
    else            chk("latency_min", dcyc - e.acc >= STAGES, dcyc - e.acc, STAGES);
  endtask

  // Monitor: everything is sampled at the falling edge, i.e. just ahead of the edge that acts on it.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
      chk("rst_busy", busy == 1'b0, busy, 0);
      chk("rst_data", {sign_1, expo_1, mant_1, side_out} == '0, 64'(mant_1), 0);
`ifdef MUL_PIPE_PERF_EN
      chk("rst_counters", beat_cnt == 0 && stall_cnt == 0, beat_cnt, 0);
`endif
      sb.delete();
      m_beats = 0;
      m_stalls = 0;
      prev_stall = 0;
    end else begin
      chk("busy", busy == (sb.size() != 0), busy, sb.size() != 0);
      chk("in_ready", in_ready == (!flush && (sb.size() < STAGES || out_ready)),
          in_ready, !flush && (sb.size() < STAGES || out_ready));
      if (prev_stall) begin
        chk("hold_valid", out_valid == 1'b1, out_valid, 1);
        chk("hold_data", {sign_1, expo_1, mant_1, side_out} == {prev_sign, prev_expo, prev_mant, prev_side},
            64'(mant_1), 64'(prev_mant));
      end
`ifdef MUL_PIPE_PERF_EN
      chk("beat_cnt", beat_cnt == 32'(m_beats), beat_cnt, m_beats);
      chk("stall_cnt", stall_cnt == 32'(m_stalls), stall_cnt, m_stalls);
`endif
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1'b0, 1, 0);
        end else if (out_ready) begin
          head = sb.pop_front();
          checkOutput(head, cyc + 1);
        end
      end
      if (out_valid && out_ready) m_beats++;
      if (out_valid && !out_ready) m_stalls++;
      prev_stall = out_valid && !out_ready && !flush;
      prev_sign = sign_1; prev_expo = expo_1; prev_mant = mant_1; prev_side = side_out;
      if (flush) sb.delete();
    end
  end

  initial begin
    beat_t b;
    exp_t  e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // T1: 1.5 * 2.0
    b = '{a_sign: 0, b_sign: 0, a_sub: 0, b_sub: 0, a_expo: 127, b_expo: 128,
          a_mant: 23'h400000, b_mant: 0, side: 16'hA5A5};
    e = '{sign: 0, expo: 128, mant: 64'h6000_0000_0000, side: 16'hA5A5, acc: 0};
    strict_lat = 1;
    applyStimulus(b, e);
    drain();

    // T2: smallest subnormal * 1.0
    b = '{a_sign: 1, b_sign: 0, a_sub: 1, b_sub: 0, a_expo: 0, b_expo: 127,
          a_mant: 23'h000001, b_mant: 0, side: 16'h0F0F};
    e = '{sign: 1, expo: 1, mant: 64'h80_0000, side: 16'h0F0F, acc: 0};
    applyStimulus(b, e);
    drain();

    // T3: 8 back-to-back beats with free-running output
    applyRandom(8, 0);
    drain();
    strict_lat = 0;

    // T4: backpressure after two beats, then release
    rdy_mode = 2;
    applyRandom(2, 0);
    fork
      begin b = randBeat(); applyStimulus(b, refModel(b)); end
      begin idle(3); rdy_mode = 0; end
    join
    drain();

    // T5: flush with two beats in flight and a coincident input beat
    rdy_mode = 2;
    applyRandom(2, 0);
    flushPipe(1'b1);
    rdy_mode = 0;
    idle(4);

    // Random traffic with random backpressure and occasional flushes
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      applyRandom(8, 2);
      if ($urandom_range(0, 2) == 0) flushPipe(1'($urandom_range(0, 1)));
    end
    drain();

    // T6: three stall cycles then four deliveries, then reset mid-stream
    rdy_mode = 2;
    applyRandom(1, 0);
    idle(3);
    rdy_mode = 0;
    applyRandom(3, 0);
    drain();
    rdy_mode = 2;
    applyRandom(2, 0);
    pulseReset();
    rdy_mode = 0;
    idle(4);
    applyRandom(4, 1);
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
